// File: rtl/imm_gen_stage_pkg.sv
// Shared types and RISC-V major opcodes for the immediate-generation stage.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] FENCE     = 7'b0001111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Upstream/downstream handshake bundle of the immediate-generation stage.
interface imm_gen_stage_if #(
  parameter int XLEN = 32,
  parameter int SB_W = 32
);
  import imm_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [SB_W-1:0] in_sb;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  imm_type_e       out_type;
  logic            out_illegal;
  logic [31:0]     out_instr;
  logic [SB_W-1:0] out_sb;

  modport master (
    output in_valid, in_instr, in_sb, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_illegal, out_instr, out_sb
  );

  modport slave (
    input  in_valid, in_instr, in_sb, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_illegal, out_instr, out_sb
  );

endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational RISC-V immediate decode: instruction word -> extended imm, format, illegal flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_type_e       o_type,
  output logic            o_illegal
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]      w_opcode;
  logic            w_funct3_msb;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_z;

  assign w_opcode     = i_instr[6:0];
  assign w_funct3_msb = i_instr[14];

  assign w_imm_i = XLEN'($signed(i_instr[31:20]));
  assign w_imm_s = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
  assign w_imm_b = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({i_instr[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
  assign w_imm_z = XLEN'(i_instr[19:15]);

  always_comb begin
    o_imm     = '0;
    o_type    = IMM_NONE;
    o_illegal = 1'b0;
    case (w_opcode)
      OP_IMM, LOAD, JALR: begin
        o_imm  = w_imm_i;
        o_type = IMM_I;
      end
      STORE: begin
        o_imm  = w_imm_s;
        o_type = IMM_S;
      end
      BRANCH: begin
        o_imm  = w_imm_b;
        o_type = IMM_B;
      end
      LUI, AUIPC: begin
        o_imm  = w_imm_u;
        o_type = IMM_U;
      end
      JAL: begin
        o_imm  = w_imm_j;
        o_type = IMM_J;
      end
      SYSTEM: begin
        // CSR immediate forms carry a 5-bit zero-extended uimm in the rs1 field
        if (w_funct3_msb) begin
          o_imm  = w_imm_z;
          o_type = IMM_Z;
        end
      end
      OP, FENCE: begin
        o_illegal = 1'b0;
      end
      OP_IMM_32: begin
        if (RV64) begin
          o_imm  = w_imm_i;
          o_type = IMM_I;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_32: begin
        o_illegal = !RV64;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase

    // Compressed or malformed encodings never reach a legal decode
    if (i_instr[1:0] != 2'b11) begin
      o_imm     = '0;
      o_type    = IMM_NONE;
      o_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode on input, 2-entry skid buffer toward execute.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SB_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  imm_gen_stage_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_type_e       typ;
    logic            illegal;
    logic [31:0]     instr;
    logic [SB_W-1:0] sb;
  } entry_t;

  logic [XLEN-1:0] w_dec_imm;
  imm_type_e       w_dec_type;
  logic            w_dec_illegal;
  entry_t          w_new;

  entry_t r_m;
  entry_t r_k;
  logic   r_m_valid;
  logic   r_k_valid;
  logic   r_in_ready;

  entry_t w_m_next;
  entry_t w_k_next;
  logic   w_m_valid_next;
  logic   w_k_valid_next;
  logic   w_in_ready_next;
  logic   w_accept;
  logic   w_consume;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .i_instr   (bus.in_instr),
    .o_imm     (w_dec_imm),
    .o_type    (w_dec_type),
    .o_illegal (w_dec_illegal)
  );

  assign w_new.imm     = w_dec_imm;
  assign w_new.typ     = w_dec_type;
  assign w_new.illegal = w_dec_illegal;
  assign w_new.instr   = bus.in_instr;
  assign w_new.sb      = bus.in_sb;

  assign w_accept  = bus.in_valid && r_in_ready;
  assign w_consume = r_m_valid && bus.out_ready;

  always_comb begin
    w_m_next       = r_m;
    w_k_next       = r_k;
    w_m_valid_next = r_m_valid;
    w_k_valid_next = r_k_valid;
    if (!r_m_valid || w_consume) begin
      // M frees up: the skid entry is older than anything arriving now
      if (r_k_valid) begin
        w_m_next       = r_k;
        w_m_valid_next = 1'b1;
        w_k_valid_next = 1'b0;
      end else begin
        w_m_valid_next = w_accept;
        if (w_accept) begin
          w_m_next = w_new;
        end
      end
    end else if (w_accept) begin
      w_k_next       = w_new;
      w_k_valid_next = 1'b1;
    end
    // Registered ready: only K occupancy matters, so no path from out_ready
    w_in_ready_next = !w_k_valid_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m        <= '0;
      r_k        <= '0;
      r_m_valid  <= 1'b0;
      r_k_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_m        <= w_m_next;
      r_k        <= w_k_next;
      r_m_valid  <= w_m_valid_next;
      r_k_valid  <= w_k_valid_next;
      r_in_ready <= w_in_ready_next;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_m_valid;
  assign bus.out_imm     = r_m.imm;
  assign bus.out_type    = r_m.typ;
  assign bus.out_illegal = r_m.illegal;
  assign bus.out_instr   = r_m.instr;
  assign bus.out_sb      = r_m.sb;

endmodule
